muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised on XLEN. It sits beside the single-cycle ALU in the execute stage and takes the funct3 of opcode 0110011 with funct7 0000001. It covers all eight M-extension ops, including MULHSU and MULHU, which the current instruction set omits. It computes one bit per cycle, uses valid/ready handshakes on both sides, takes a fast path for divide special cases, and supports pipeline flush.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One multiplier/quotient bit per cycle, valid/ready on both sides,
// fast path for divide-by-zero and signed overflow, flush support.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [ID_W-1:0] rd_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [ID_W-1:0] out_rd_id,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]      op_q;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc_hi;   // product high word / partial remainder
  logic [XLEN-1:0] acc_lo;   // product low word + multiplier / quotient + dividend
  logic [XLEN-1:0] opnd;     // multiplicand / divisor magnitude
  logic            neg_q;    // negate product or quotient
  logic            neg_r;    // negate remainder

  logic            accept;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   sign_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && in_valid && !flush;

  // Operand decode at accept: signedness, magnitudes, divide fast path
  always_comb begin
    is_div      = funct3[2];
    sgn_a       = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    sgn_b       = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg       = sgn_a & operand_a[XLEN-1];
    b_neg       = sgn_b & operand_b[XLEN-1];
    mag_a       = a_neg ? ('0 - operand_a) : operand_a;
    mag_b       = b_neg ? ('0 - operand_b) : operand_b;
    special     = 1'b0;
    special_res = '0;
    if (is_div) begin
      if (operand_b == '0) begin
        special     = 1'b1;
        special_res = funct3[1] ? operand_a : '1;
      end else if (!funct3[0] && operand_a == MOST_NEG && operand_b == '1) begin
        special     = 1'b1;
        special_res = funct3[1] ? '0 : operand_a;
      end
    end
  end

  // One iteration step: shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[XLEN-1:0] - opnd;
  end

  // Sign fix-up and result selection
  always_comb begin
    prod_s = neg_q ? ('0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    quo_s  = neg_q ? ('0 - acc_lo) : acc_lo;
    rem_s  = neg_r ? ('0 - acc_hi) : acc_hi;
    case (op_q)
      3'b000:         sign_res = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         sign_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: sign_res = quo_s;
      default:        sign_res = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (count == '0) state_nx = SIGN;
      SIGN: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Datapath: capture at accept, iterate in CALC, resolve in SIGN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      count     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      out_rd_id <= '0;
    end else begin
      if (accept) begin
        op_q      <= funct3;
        out_rd_id <= rd_id;
        count     <= CW'(XLEN - 1);
        acc_hi    <= '0;
        neg_q     <= a_neg ^ b_neg;
        neg_r     <= is_div & a_neg;
        if (is_div) begin
          acc_lo <= mag_a;
          opnd   <= mag_b;
        end else begin
          acc_lo <= mag_b;
          opnd   <= mag_a;
        end
        if (special) result <= special_res;
      end
      if (state == CALC) begin
        if (count != '0) count <= count - 1'b1;
        if (op_q[2]) begin
          acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
          acc_lo <= {acc_lo[XLEN-2:0], div_ge};
        end else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
        end
      end
      if (state == SIGN) result <= sign_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases,
// randomized ops against an arithmetic reference, backpressure, flush, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_id;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd_id;
  logic        busy;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  muldiv_unit #(.XLEN(32), .ID_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b), .rd_id(rd_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_rd_id(out_rd_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: p = {32'b0, 32'(longint'(sa * sb) >>> 32)};
      3'd2: p = {32'b0, 32'(longint'(sa * ub) >>> 32)};
      3'd3: p = {32'b0, 32'(longint'(ua * ub) >> 32)};
      3'd4: if (b == 32'h0) p = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, a};
            else p = sa / sb;
      3'd5: if (b == 32'h0) p = '1; else p = ua / ub;
      3'd6: if (b == 32'h0) p = {32'b0, a};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
            else p = sa % sb;
      default: if (b == 32'h0) p = {32'b0, a}; else p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  // Called just after a negedge; returns just after the negedge following accept
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] id);
    funct3    = f3;
    operand_a = a;
    operand_b = b;
    rd_id     = id;
    in_valid  = 1'b1;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycle 1 is the first negedge after the accept edge
  task automatic wait_valid(output int unsigned cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] id, input logic [31:0] exp);
    int unsigned cyc;
    out_ready = 1'b1;
    issue(f3, a, b, id);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, is_special(f3, a, b) ? 32'd1 : 32'd34);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd_id"}, {27'b0, out_rd_id}, {27'b0, id});
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int unsigned cyc;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  id;
    bit          saw;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; operand_a = '0; operand_b = '0; rd_id = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_out_rd_id", {27'b0, out_rd_id}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000);
    run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF);
    run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 32'hFFFF_FFFD);
    run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF);
    run("divu",   3'd5, 32'd100,        32'd7,         5'd7, 32'd14);
    run("remu",   3'd7, 32'd100,        32'd7,         5'd8, 32'd2);

    // Divide fast path
    run("divu_by_zero", 3'd5, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF);
    run("rem_by_zero",  3'd6, 32'd5,         32'd0,         5'd10, 32'd5);
    run("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    run("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

    // Randomized ops against the reference model
    for (int unsigned i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      id = 5'($urandom_range(0, 31));
      run("random", f3, a, b, id, ref_model(f3, a, b));
    end

    // Backpressure: result held, new requests ignored while DONE
    out_ready = 1'b0;
    issue(3'd5, 32'd1000, 32'd7, 5'd9);
    wait_valid(cyc);
    check("bp_latency", cyc, 32'd34);
    funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd5; rd_id = 5'd4; in_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      check("bp_result_stable", result, 32'd142);
      check("bp_rd_id_stable", {27'b0, out_rd_id}, 32'd9);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", {31'b0, out_valid}, 32'd0);
    check("bp_released_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp_next_latency", cyc, 32'd34);
    check("bp_next_result", result, 32'd15);
    check("bp_next_rd_id", {27'b0, out_rd_id}, 32'd4);
    @(negedge clk);

    // Flush during CALC
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
    repeat (9) @(negedge clk);
    check("flush_calc_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_idle", {31'b0, busy}, 32'd0);
    check("flush_calc_in_ready", {31'b0, in_ready}, 32'd1);
    saw = 1'b0;
    repeat (40) begin
      saw |= out_valid;
      @(negedge clk);
    end
    check("flush_calc_no_result", {31'b0, saw}, 32'd0);
    run("after_flush_mul", 3'd0, 32'd3, 32'd4, 5'd13, 32'd12);

    // Flush with in_valid in IDLE is not an accept
    funct3 = 3'd0; operand_a = 32'd2; operand_b = 32'd2; rd_id = 5'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_not_accepted", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("flush_idle_no_result", {31'b0, out_valid}, 32'd0);

    // Flush together with out_ready in DONE
    out_ready = 1'b0;
    issue(3'd7, 32'd100, 32'd7, 5'd3);
    wait_valid(cyc);
    check("flush_done_result", result, 32'd2);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_valid", {31'b0, out_valid}, 32'd0);
    check("flush_done_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("flush_done_stays_idle", {31'b0, busy}, 32'd0);

    // Reset mid-CALC
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd21);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_out_rd_id", {27'b0, out_rd_id}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    saw = 1'b0;
    repeat (40) begin
      saw |= out_valid;
      @(negedge clk);
    end
    check("midrst_no_result", {31'b0, saw}, 32'd0);
    run("after_reset_mul", 3'd0, 32'd3, 32'd4, 5'd6, 32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
